// File: rtl/lcd_fmt_pkg.sv
// Shared types, ASCII constants, banner text and packing helpers for the LCD status formatter.
package lcd_fmt_pkg;

  localparam int LINE_LEN   = 16;
  localparam int NUM_DIGITS = 5;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int DEC_W      = 8 * NUM_DIGITS;

  typedef logic [0:LINE_LEN-1][7:0] lcdLine_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CONV,
    COMMIT,
    HOLDOFF
  } fmtState_t;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam lcdLine_t BANNER0 = "AUDIO EFFECTOR  ";
  localparam lcdLine_t BANNER1 = "WAITING...      ";

  localparam logic [DEC_W-1:0] TAG_LIVE = " LIVE";
  localparam logic [DEC_W-1:0] TAG_HOLD = " HOLD";

  // Most significant BCD digit lands in the leftmost character.
  function automatic logic [DEC_W-1:0] bcdToAscii(input logic [BCD_W-1:0] bcd);
    logic [DEC_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[8*i +: 8] = ASCII_0 + {4'h0, bcd[4*i +: 4]};
    end
    return r;
  endfunction

  function automatic logic [7:0] signChar(input logic neg);
    return neg ? ASCII_MINUS : ASCII_PLUS;
  endfunction

endpackage

// File: rtl/bcd_serial16.sv
// Iterative double-dabble: 16-bit binary to 5 BCD digits, one shift per cycle.
// Start is sampled on an edge that also performs the first shift; oDone is high the cycle after the 16th shift.
module bcd_serial16 (
  input  logic        iCLK_50,
  input  logic        iRST_N,
  input  logic        iStart,
  input  logic [15:0] iBin,
  output logic [19:0] oBcd,
  output logic        oDone
);

  logic [35:0] shiftReg;
  logic [3:0]  bitCnt;

  function automatic logic [35:0] dabble(input logic [35:0] s);
    logic [35:0] t;
    t = s;
    for (int i = 0; i < 5; i++) begin
      if (t[16+4*i +: 4] >= 4'd5) t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
    end
    return {t[34:0], 1'b0};
  endfunction

  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) begin
      shiftReg <= '0;
      bitCnt   <= '0;
      oDone    <= 1'b0;
    end else if (iStart) begin
      shiftReg <= dabble({20'd0, iBin});
      bitCnt   <= 4'd15;
      oDone    <= 1'b0;
    end else if (bitCnt != 4'd0) begin
      shiftReg <= dabble(shiftReg);
      bitCnt   <= bitCnt - 4'd1;
      oDone    <= (bitCnt == 4'd1);
    end else begin
      oDone    <= 1'b0;
    end
  end

  assign oBcd = shiftReg[35:16];

endmodule

// File: rtl/lcd_status_formatter.sv
// Converts one status frame (signed L/R levels, unsigned peak) into two 16-char LCD lines.
// Build option: define PEAK_HOLD_EN to show a held peak (tag " HOLD") instead of the live peak.
//
// state   | meaning
// IDLE    | oReady high, waiting for a frame
// LOAD    | sign flags and magnitudes registered
// CONV    | 48 cycles: L, R, peak through the shared BCD engine
// COMMIT  | both lines and oUpdate written on the leaving edge
// HOLDOFF | rate-limit down-counter before accepting again
module lcd_status_formatter
  import lcd_fmt_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 5000000,
  parameter int unsigned HOLD_FRAMES    = 8
) (
  input  logic                          iCLK_50,
  input  logic                          iRST_N,
  input  logic                          iValid,
  output logic                          oReady,
  input  logic [15:0]                   iChanL,
  input  logic [15:0]                   iChanR,
  input  logic [15:0]                   iPeak,
  output logic [0:LINE_LEN-1][7:0]      oString0,
  output logic [0:LINE_LEN-1][7:0]      oString1,
  output logic                          oUpdate
);

  localparam int HC_W = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLDOFF_CYCLES);
  localparam logic [5:0] CONV_CYCLES = 6'd48;

  if (HOLD_FRAMES < 1) begin : gBadHoldFrames
    $error("HOLD_FRAMES must be at least 1");
  end

  fmtState_t       state, stateNext;
  logic            armed;
  logic            accept;
  logic            bcdStart, bcdDone;
  logic [15:0]     bcdBin;
  logic [19:0]     bcdOut;
  logic [15:0]     chanLQ, chanRQ, magL, magR, peakShown;
  logic            negL, negR;
  logic [5:0]      convCnt;
  logic [HC_W-1:0] holdCnt;
  logic [19:0]     digL, digR;
  lcdLine_t        line0New, line1New;

  assign accept = iValid & oReady;

`ifdef PEAK_HOLD_EN
  localparam int FC_W = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(HOLD_FRAMES - 1);
  localparam logic [DEC_W-1:0] PEAK_TAG = TAG_HOLD;

  logic [15:0]     heldPeak;
  logic [FC_W-1:0] frameCnt;

  // Held peak refreshes on a new maximum or once it has survived HOLD_FRAMES frames.
  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) begin
      heldPeak <= '0;
      frameCnt <= '0;
    end else if (accept) begin
      if (iPeak >= heldPeak || frameCnt == FC_LAST) begin
        heldPeak <= iPeak;
        frameCnt <= '0;
      end else begin
        frameCnt <= frameCnt + 1'b1;
      end
    end
  end

  assign peakShown = heldPeak;
`else
  localparam logic [DEC_W-1:0] PEAK_TAG = TAG_LIVE;

  logic [15:0] peakQ;

  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) peakQ <= '0;
    else if (accept) peakQ <= iPeak;
  end

  assign peakShown = peakQ;
`endif

  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) state <= IDLE;
    else state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept) stateNext = LOAD;
      LOAD:    stateNext = CONV;
      CONV:    if (convCnt == 6'd1) stateNext = COMMIT;
      COMMIT:  stateNext = HOLDOFF;
      HOLDOFF: if (holdCnt == '0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // The engine is restarted at the 48/32/16 marks, one value per 16-cycle slot.
  always_comb begin
    oReady   = (state == IDLE) && armed;
    bcdStart = (state == CONV) &&
               (convCnt == CONV_CYCLES || convCnt == 6'd32 || convCnt == 6'd16);
    if (convCnt > 6'd32) bcdBin = magL;
    else if (convCnt > 6'd16) bcdBin = magR;
    else bcdBin = peakShown;
  end

  bcd_serial16 uBcd (
    .iCLK_50 (iCLK_50),
    .iRST_N  (iRST_N),
    .iStart  (bcdStart),
    .iBin    (bcdBin),
    .oBcd    (bcdOut),
    .oDone   (bcdDone)
  );

  assign line0New = {"L", signChar(negL), bcdToAscii(digL),
                     " R", signChar(negR), bcdToAscii(digR), ASCII_SPACE};
  assign line1New = {"PEAK ", bcdToAscii(bcdOut), ASCII_SPACE, PEAK_TAG};

  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) begin
      armed    <= 1'b0;
      chanLQ   <= '0;
      chanRQ   <= '0;
      magL     <= '0;
      magR     <= '0;
      negL     <= 1'b0;
      negR     <= 1'b0;
      convCnt  <= '0;
      holdCnt  <= '0;
      digL     <= '0;
      digR     <= '0;
      oString0 <= BANNER0;
      oString1 <= BANNER1;
      oUpdate  <= 1'b0;
    end else begin
      armed   <= 1'b1;
      oUpdate <= 1'b0;
      if (accept) begin
        chanLQ <= iChanL;
        chanRQ <= iChanR;
      end
      if (state == LOAD) begin
        negL    <= chanLQ[15];
        negR    <= chanRQ[15];
        magL    <= chanLQ[15] ? (~chanLQ + 16'd1) : chanLQ;
        magR    <= chanRQ[15] ? (~chanRQ + 16'd1) : chanRQ;
        convCnt <= CONV_CYCLES;
      end
      if (state == CONV) begin
        convCnt <= convCnt - 6'd1;
        if (bcdDone && convCnt == 6'd32) digL <= bcdOut;
        if (bcdDone && convCnt == 6'd16) digR <= bcdOut;
      end
      // Peak digits are taken straight from the engine on the commit edge.
      if (state == COMMIT) begin
        oString0 <= line0New;
        oString1 <= line1New;
        oUpdate  <= 1'b1;
        holdCnt  <= HOLD_LOAD;
      end
      if (state == HOLDOFF && holdCnt != '0) holdCnt <= holdCnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_status_formatter.sv
// Self-checking bench for lcd_status_formatter: string-level reference model plus directed literal checks.
module tb_lcd_status_formatter;

  localparam int H  = 10;
  localparam int HF = 3;

  typedef logic [0:15][7:0] line_t;

  logic        iCLK_50 = 1'b0;
  logic        iRST_N  = 1'b0;
  logic        iValid  = 1'b0;
  logic        oReady, oUpdate;
  logic [15:0] iChanL = '0, iChanR = '0, iPeak = '0;
  line_t       oString0, oString1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  lcd_status_formatter #(.HOLDOFF_CYCLES(H), .HOLD_FRAMES(HF)) dut (
    .iCLK_50  (iCLK_50),
    .iRST_N   (iRST_N),
    .iValid   (iValid),
    .oReady   (oReady),
    .iChanL   (iChanL),
    .iChanR   (iChanR),
    .iPeak    (iPeak),
    .oString0 (oString0),
    .oString1 (oString1),
    .oUpdate  (oUpdate)
  );

  always #10 iCLK_50 = ~iCLK_50;

  function automatic string tagStr();
`ifdef PEAK_HOLD_EN
    return " HOLD";
`else
    return " LIVE";
`endif
  endfunction

  function automatic line_t toLine(input string s);
    line_t r;
    for (int i = 0; i < 16; i++) r[i] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  function automatic string fmtSigned(input logic [15:0] v);
    int x;
    x = int'($signed(v));
    if (x < 0) return $sformatf("-%05d", -x);
    return $sformatf("+%05d", x);
  endfunction

  task automatic check(input string name, input bit ok, input string act, input string exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got '%s' expected '%s' (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: event times and strings computed from the frame rules.
  line_t expS0, expS1, pend0, pend1;
  bit    expReady = 0, expUpd = 0, modelOn = 0, inReset = 0;
  int    commitCyc = -1, readyCyc = -1;
  int    heldP = 0, frameCnt = 0, shown = 0, pk = 0;

  always @(posedge iCLK_50) begin
    cyc++;
    if (!iRST_N) begin
      modelOn   = 1;
      inReset   = 1;
      expReady  = 0;
      expUpd    = 0;
      expS0     = toLine("AUDIO EFFECTOR");
      expS1     = toLine("WAITING...");
      commitCyc = -1;
      readyCyc  = -1;
      heldP     = 0;
      frameCnt  = 0;
    end else if (modelOn) begin
      expUpd = 0;
      if (inReset) begin
        inReset  = 0;
        expReady = 1;
      end else if (expReady && iValid) begin
        expReady = 0;
        pk = int'(iPeak);
        shown = pk;
`ifdef PEAK_HOLD_EN
        if (pk >= heldP || frameCnt == HF - 1) begin
          heldP = pk;
          frameCnt = 0;
        end else begin
          frameCnt++;
        end
        shown = heldP;
`endif
        pend0 = toLine($sformatf("L%s R%s ", fmtSigned(iChanL), fmtSigned(iChanR)));
        pend1 = toLine($sformatf("PEAK %05d %s", shown, tagStr()));
        commitCyc = cyc + 50;
        readyCyc  = cyc + 51 + H;
      end else if (cyc == readyCyc) begin
        expReady = 1;
      end
      if (cyc == commitCyc) begin
        expS0  = pend0;
        expS1  = pend1;
        expUpd = 1;
      end
    end
  end

  always @(negedge iCLK_50) begin
    if (modelOn) begin
      check("ready", oReady === expReady, $sformatf("%b", oReady), $sformatf("%b", expReady));
      check("update", oUpdate === expUpd, $sformatf("%b", oUpdate), $sformatf("%b", expUpd));
      check("line0", oString0 === expS0, $sformatf("%s", oString0), $sformatf("%s", expS0));
      check("line1", oString1 === expS1, $sformatf("%s", oString1), $sformatf("%s", expS1));
    end
  end

  always @(posedge iCLK_50) begin
    if (cyc > 30000) begin
      $display("FAIL watchdog: cycle %0d exceeded budget 30000", cyc);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
    end
  end

  // Returns on the negedge right after the accepting edge; acc is that edge's cycle number.
  task automatic sendFrame(input logic [15:0] l, input logic [15:0] r, input logic [15:0] p,
                           input bit keepValid, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge iCLK_50);
    iChanL = l;
    iChanR = r;
    iPeak  = p;
    iValid = 1'b1;
    while (!oReady && n < 200) begin
      @(negedge iCLK_50);
      n++;
    end
    if (n >= 200) check("accept_timeout", 1'b0, "oReady low", "oReady high within 200 cycles");
    @(posedge iCLK_50);
    #1 acc = cyc;
    @(negedge iCLK_50);
    if (!keepValid) iValid = 1'b0;
  endtask

  task automatic waitUpdate(output int upd);
    upd = -1;
    for (int n = 0; n < 120; n++) begin
      if (oUpdate) begin
        upd = cyc;
        break;
      end
      @(negedge iCLK_50);
    end
    if (upd < 0) check("update_timeout", 1'b0, "no pulse", "oUpdate within 120 cycles");
  endtask

  function automatic logic [15:0] pickVal();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int acc, upd, rise, updCount;
    bit seenUpd;
    int peaks [4];
    int want  [4];
    peaks = '{500, 100, 200, 50};
`ifdef PEAK_HOLD_EN
    want = '{500, 500, 500, 50};
`else
    want = '{500, 100, 200, 50};
`endif

    iRST_N = 1'b0;
    repeat (10) @(negedge iCLK_50);
    check("rst_line0", oString0 === toLine("AUDIO EFFECTOR  "), $sformatf("%s", oString0), "AUDIO EFFECTOR  ");
    check("rst_line1", oString1 === toLine("WAITING...      "), $sformatf("%s", oString1), "WAITING...      ");
    check("rst_ready", oReady === 1'b0, $sformatf("%b", oReady), "0");
    iRST_N = 1'b1;
    @(negedge iCLK_50);
    check("rel_ready", oReady === 1'b1, $sformatf("%b", oReady), "1");
    check("rel_update", oUpdate === 1'b0, $sformatf("%b", oUpdate), "0");

    sendFrame(16'd1234, 16'hFFC8, 16'd32767, 1'b0, acc);
    waitUpdate(upd);
    check("latency_A", upd - acc == 50, $sformatf("%0d", upd - acc), "50");
    check("A_line0", oString0 === toLine("L+01234 R-00056 "), $sformatf("%s", oString0), "L+01234 R-00056 ");
    check("A_line1", oString1 === toLine({"PEAK 32767 ", tagStr()}), $sformatf("%s", oString1), {"PEAK 32767 ", tagStr()});
    @(negedge iCLK_50);
    check("A_pulse_end", oUpdate === 1'b0, $sformatf("%b", oUpdate), "0");

    sendFrame(16'h8000, 16'h0000, 16'hFFFF, 1'b0, acc);
    waitUpdate(upd);
    check("B_line0", oString0 === toLine("L-32768 R+00000 "), $sformatf("%s", oString0), "L-32768 R+00000 ");
    check("B_line1", oString1 === toLine({"PEAK 65535 ", tagStr()}), $sformatf("%s", oString1), {"PEAK 65535 ", tagStr()});

    // iValid held high with inputs scrambled during conversion.
    sendFrame(16'd7, 16'hFFF9, 16'd7, 1'b1, acc);
    rise = -1;
    seenUpd = 0;
    for (int k = 0; k < 120; k++) begin
      if (oUpdate) begin
        seenUpd = 1;
        check("C_line0", oString0 === toLine("L+00007 R-00007 "), $sformatf("%s", oString0), "L+00007 R-00007 ");
      end
      if (oReady) begin
        rise = cyc;
        break;
      end
      iChanL = 16'($urandom);
      iChanR = 16'($urandom);
      iPeak  = 16'($urandom);
      @(negedge iCLK_50);
    end
    check("C_update_seen", seenUpd, $sformatf("%0d", seenUpd), "1");
    check("C_ready_rise", rise - acc == 51 + H, $sformatf("%0d", rise - acc), $sformatf("%0d", 51 + H));
    @(negedge iCLK_50);
    iValid = 1'b0;

    // Reset at T+20 aborts the frame.
    sendFrame(16'd111, 16'hFF22, 16'd333, 1'b0, acc);
    repeat (19) @(negedge iCLK_50);
    iRST_N = 1'b0;
    @(negedge iCLK_50);
    iRST_N = 1'b1;
    check("abort_line0", oString0 === toLine("AUDIO EFFECTOR  "), $sformatf("%s", oString0), "AUDIO EFFECTOR  ");
    check("abort_line1", oString1 === toLine("WAITING...      "), $sformatf("%s", oString1), "WAITING...      ");
    updCount = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge iCLK_50);
      if (oUpdate) updCount++;
    end
    check("abort_no_update", updCount == 0, $sformatf("%0d", updCount), "0");

    for (int i = 0; i < 4; i++) begin
      sendFrame(16'(i + 1), 16'(-(i + 1)), 16'(peaks[i]), 1'b0, acc);
      waitUpdate(upd);
      if (i == 0)
        check("post_abort_line0", oString0 === toLine("L+00001 R-00001 "), $sformatf("%s", oString0), "L+00001 R-00001 ");
      check($sformatf("peak_seq%0d", i), oString1 === toLine($sformatf("PEAK %05d %s", want[i], tagStr())),
            $sformatf("%s", oString1), $sformatf("PEAK %05d %s", want[i], tagStr()));
    end

    for (int f = 0; f < 25; f++) begin
      repeat ($urandom_range(0, 3)) @(negedge iCLK_50);
      sendFrame(pickVal(), pickVal(), pickVal(), 1'b0, acc);
      waitUpdate(upd);
      check("rand_latency", upd - acc == 50, $sformatf("%0d", upd - acc), "50");
    end

    repeat (20) @(negedge iCLK_50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
